sram_rr_arbiter: RTL

//  Shares one single-port synchronous SRAM (1-cycle registered read) between
//  NUM_REQ requesters using round-robin arbitration with a burst quantum.

---
 rtl/sram_arb_pkg.sv | 12 +
 rtl/sram_rr_arbiter_rr_pick.sv | 47 ++++
 rtl/sram_rr_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM round-robin arbiter.
// Holds the FSM state encoding and the burst counter width.
package sram_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam int CNT_W = 4;

endpackage

// File: rtl/sram_rr_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req at or after start (wrapping).
// Ports: req (candidates), start (scan origin) -> gnt (one-hot), idx, any.
module rr_pick
    import sram_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Rotate so that bit 0 is the requester at start.
    logic [N-1:0] rot;
    int           off;
    int           sum;

    assign rot = N'({req, req} >> start);

    always_comb begin
        off = 0;
        any = 1'b0;
        // Descending scan: the lowest offset wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = k;
                any = 1'b1;
            end
        end
        sum = int'(start) + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        idx = IW'(sum);
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = any && (idx == IW'(i));
        end
    end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM with burst quantum.
// Ports: clk, rst (sync, active-low), per-requester valid/ready/we/addr/
// wdata, per-requester rsp_valid, shared rsp_rdata, SRAM addr/wdata/ena/rdata.
module sram_rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WL_ADDR = 8,
    parameter int WL_DATA = 32,
    parameter int QUANTUM = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_we,
    input  logic [NUM_REQ*WL_ADDR-1:0] req_addr,
    input  logic [NUM_REQ*WL_DATA-1:0] req_wdata,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [WL_DATA-1:0]         rsp_rdata,
    output logic [WL_ADDR-1:0]         sram_addr,
    output logic [WL_DATA-1:0]         sram_wdata,
    output logic                       sram_ena,
    input  logic [WL_DATA-1:0]         sram_rdata
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] QMAX = CNT_W'(QUANTUM);

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

    logic [NUM_REQ-1:0] owner_oh;
    logic [NUM_REQ-1:0] pick_vec;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [IW-1:0]      gnt_idx;
    logic               granted;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (int'(i) == NUM_REQ - 1) begin
            return '0;
        end
        return i + IW'(1);
    endfunction

    assign owner_oh = NUM_REQ'(1) << owner_q;

    // While owning, rr_ptr is owner+1, so masking the owner makes the
    // picker return the next valid requester after the owner.
    assign pick_vec = (state_q == OWN) ? (req_valid & ~owner_oh)
                                       : req_valid;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req   (pick_vec),
        .start (rr_ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        gnt_oh   = '0;
        gnt_idx  = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_oh   = pick_gnt;
                    gnt_idx  = pick_idx;
                    state_d  = OWN;
                    owner_d  = pick_idx;
                    rr_ptr_d = next_idx(pick_idx);
                    beat_d   = CNT_W'(1);
                end
            end
            OWN: begin
                if (!req_valid[owner_q] ||
                    (beat_q == QMAX && pick_any)) begin
                    if (pick_any) begin
                        gnt_oh   = pick_gnt;
                        gnt_idx  = pick_idx;
                        owner_d  = pick_idx;
                        rr_ptr_d = next_idx(pick_idx);
                        beat_d   = CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gnt_oh  = owner_oh;
                    gnt_idx = owner_q;
                    // Saturate: a lone owner keeps streaming.
                    if (beat_q != QMAX) begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    assign req_ready = rst ? gnt_oh : '0;
    assign granted   = |req_ready;

    always_comb begin
        sram_addr  = '0;
        sram_wdata = '0;
        sram_ena   = 1'b0;
        if (granted) begin
            sram_addr  = req_addr[int'(gnt_idx)*WL_ADDR +: WL_ADDR];
            sram_wdata = req_wdata[int'(gnt_idx)*WL_DATA +: WL_DATA];
            sram_ena   = req_we[gnt_idx];
        end
    end

    assign rsp_valid_d = req_ready & ~req_we;

    // Gating with rst drops a response already in flight.
    assign rsp_valid = rst ? rsp_valid_q : '0;
    assign rsp_rdata = sram_rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            beat_q      <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_q      <= beat_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

endmodule
